// File: rtl/gsim_mx.sv
// Banded symmetric matrix-vector product b = M*x over a 16-element Q16.16 frame.
// Loads x serially, then streams b[0..15] (Q22.16) on 16 consecutive cycles.
module gsim_mx (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_en,
    input  logic [31:0] x_in,
    output logic        busy,
    output logic        out_valid,
    output logic [37:0] b_out
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE
    } state_t;

    state_t             state;
    logic [3:0]         load_cnt;
    logic [4:0]         k;
    logic [31:0]        x_buf [16];
    logic               buf_we;
    logic [3:0]         buf_idx;
    logic signed [37:0] pad [22];
    logic [4:0]         base;
    logic signed [37:0] b_next;

    // NOTE: every variable driven from always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        buf_we  = 1'b0;
        buf_idx = load_cnt;
        if (state == IDLE && in_en) begin
            buf_we  = 1'b1;
            buf_idx = 4'd0;
        end else if (state == LOAD && in_en) begin
            buf_we  = 1'b1;
        end
    end

    // NOTE: the sample buffer is deliberately not reset; a full frame always overwrites all 16 entries before use.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            x_buf[buf_idx] <= x_in;
        end
    end

    // Zero padding of three entries on each side turns out-of-range taps into plain zeros.
    always_comb begin
        for (int i = 0; i < 22; i++) begin
            pad[i] = '0;
        end
        for (int i = 0; i < 16; i++) begin
            pad[i + 3] = $signed({{6{x_buf[i][31]}}, x_buf[i]});
        end
    end

    assign base = {1'b0, k[3:0]};

    always_comb begin
        b_next = 38'sd20 * pad[base + 5'd3]
               - 38'sd13 * (pad[base + 5'd2] + pad[base + 5'd4])
               + 38'sd6  * (pad[base + 5'd1] + pad[base + 5'd5])
               - (pad[base] + pad[base + 5'd6]);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            load_cnt  <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            b_out     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_en) begin
                        load_cnt <= 4'd1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_en) begin
                        if (load_cnt == 4'd15) begin
                            state    <= COMPUTE;
                            busy     <= 1'b1;
                            k        <= '0;
                            load_cnt <= '0;
                        end else begin
                            load_cnt <= load_cnt + 4'd1;
                        end
                    end
                end
                COMPUTE: begin
                    // k==16 is the single trailing cycle that drops valid and returns to IDLE.
                    if (k == 5'd16) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        k         <= '0;
                        state     <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                        b_out     <= b_next;
                        k         <= k + 5'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gsim_mx.sv
// Scoreboard bench for gsim_mx: stimulus queues expected b values with their due cycle,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_gsim_mx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_en = 1'b0;
    logic [31:0] x_in = '0;
    logic        busy;
    logic        out_valid;
    logic [37:0] b_out;

    gsim_mx dut (
        .clk       (clk),
        .reset     (reset),
        .in_en     (in_en),
        .x_in      (x_in),
        .busy      (busy),
        .out_valid (out_valid),
        .b_out     (b_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [37:0] b;
        int          at;
        int          idx;
    } exp_t;

    typedef logic [31:0] frame_t [16];
    typedef logic [37:0] bvec_t [16];

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every out_valid cycle must match the oldest queued expectation, value and cycle.
    exp_t e;
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out_valid actual=%0h required=none cycle=%0d", b_out, cyc);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("b[%0d]", e.idx), {26'd0, b_out}, {26'd0, e.b});
                    check($sformatf("b[%0d]_cycle", e.idx), 64'(cyc), 64'(e.at));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Exact reference of the banded product, in 64-bit arithmetic.
    function automatic logic [37:0] ref_b(input frame_t xs, input int k);
        longint acc;
        longint xv;
        int     c [7];
        c   = '{-1, 6, -13, 20, -13, 6, -1};
        acc = 0;
        for (int d = -3; d <= 3; d++) begin
            if (k + d >= 0 && k + d <= 15) begin
                xv  = longint'($signed(xs[k + d]));
                acc = acc + longint'(c[d + 3]) * xv;
            end
        end
        return acc[37:0];
    endfunction

    function automatic bvec_t model(input frame_t xs);
        bvec_t r;
        for (int k = 0; k < 16; k++) r[k] = ref_b(xs, k);
        return r;
    endfunction

    task automatic drive(input logic en, input logic [31:0] x);
        in_en = en;
        x_in  = x;
        @(posedge clk);
        #1;
    endtask

    // Loads a frame (optional gaps), queues expectations, optionally pokes in_en during COMPUTE,
    // and returns at E+17 (+1) after checking the idle handshake.
    task automatic run_frame(input frame_t xs, input bvec_t exp_b, input int gap, input bit poke);
        int ee;
        for (int j = 0; j < 16; j++) begin
            drive(1'b1, xs[j]);
            if (j < 15) repeat (gap) drive(1'b0, $urandom);
        end
        ee = cyc;
        for (int k = 0; k < 16; k++) sb.push_back('{exp_b[k], ee + 1 + k, k});
        check("busy_at_E", 64'(busy), 64'(1));
        check("out_valid_at_E", 64'(out_valid), 64'(0));
        while (cyc < ee + 17) drive((poke && cyc < ee + 12) ? 1'b1 : 1'b0, $urandom);
        in_en = 1'b0;
        check("busy_at_E17", 64'(busy), 64'(0));
        check("out_valid_at_E17", 64'(out_valid), 64'(0));
        check("b_out_hold_at_E17", {26'd0, b_out}, {26'd0, exp_b[15]});
        check("sb_drained_at_E17", 64'(sb.size()), 64'(0));
    endtask

    frame_t fa, fb, fc, fd, fp, fq, fr;
    bvec_t  ea, eb, ec, ed, ep, eq, er;
    int     ones_tbl [16];
    int     ee;

    initial begin
        ones_tbl = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};
        for (int j = 0; j < 16; j++) begin
            fa[j] = 32'h0000_0000;
            ea[j] = 38'h0;
            fb[j] = (j == 0) ? 32'h0001_0000 : 32'h0;
            eb[j] = 38'h0;
            fc[j] = 32'h0001_0000;
            ec[j] = 38'(longint'(ones_tbl[j]) * 65536);
            fd[j] = (j % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            fp[j] = 32'(j * 32'h0001_2345) - 32'h0008_0000;
            fq[j] = 32'(j * j * 32'h0001_1111) ^ 32'hA5A5_0000;
            fr[j] = 32'hFFF0_0000 + 32'(j * 32'h0003_7777);
        end
        eb[0] = 38'h0000140000;
        eb[1] = 38'h3FFFF30000;
        eb[2] = 38'h0000060000;
        eb[3] = 38'h3FFFFF0000;
        ed = model(fd);
        ep = model(fp);
        eq = model(fq);
        er = model(fr);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_b_out", {26'd0, b_out}, 64'(0));
        reset = 1'b1;
        repeat (2) drive(1'b0, 32'h0);

        run_frame(fa, ea, 0, 1'b0);
        run_frame(fb, eb, 0, 1'b0);
        run_frame(fc, ec, 0, 1'b0);
        run_frame(fd, ed, 0, 1'b0);

        // Gap-free reference, then gapped with COMPUTE pokes, then a back-to-back frame.
        run_frame(fp, ep, 0, 1'b0);
        run_frame(fp, ep, 3, 1'b1);
        run_frame(fq, eq, 0, 1'b0);

        // Partial frame waits in LOAD forever; reset then abandons it.
        for (int j = 0; j < 10; j++) drive(1'b1, fr[j]);
        repeat (30) drive(1'b0, 32'h0);
        check("partial_busy", 64'(busy), 64'(0));
        reset = 1'b0;
        drive(1'b0, 32'h0);
        reset = 1'b1;
        drive(1'b0, 32'h0);

        // Reset asserted at E+5 of a running frame.
        for (int j = 0; j < 16; j++) drive(1'b1, fq[j]);
        ee = cyc;
        for (int k = 0; k < 16; k++) sb.push_back('{eq[k], ee + 1 + k, k});
        while (cyc < ee + 5) drive(1'b0, 32'h0);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_b_out", {26'd0, b_out}, 64'(0));
        check("rst_pending", 64'(sb.size()), 64'(12));
        sb.delete();
        repeat (3) drive(1'b1, $urandom);
        reset = 1'b1;
        repeat (20) drive(1'b0, 32'h0);
        check("post_rst_idle_busy", 64'(busy), 64'(0));

        run_frame(fr, er, 0, 1'b0);
        repeat (5) drive(1'b0, 32'h0);
        check("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
